// File: rtl/sw_input_frontend.sv
// ----------------------------------------------------------------------------
// sw_input_frontend: sync + debounce of 9 board inputs, button handshake to CPU
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sw_input_frontend #(
    parameter int DB_CYCLES = 16,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] raw_sw_i,
    output logic [8:0] sw_o,
    output logic       press_o,
    output logic       release_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [8:0]    sync1_q, sync2_q;
    logic [8:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    deb_q, deb_d;
    state_t        state_q;

    // Whole-vector debounce: any toggling bit restarts the stability count.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d  = cand_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= raw_sw_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    // Operand is frozen while the button is held so software reads a stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sw_o      <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (deb_q[8]) begin
                        state_q <= HELD;
                        sw_o    <= {1'b1, deb_q[7:0]};
                        press_o <= 1'b1;
                    end else begin
                        sw_o    <= {1'b0, deb_q[7:0]};
                    end
                end
                HELD: begin
                    if (!deb_q[8]) begin
                        state_q   <= IDLE;
                        sw_o      <= {1'b0, deb_q[7:0]};
                        release_o <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sw_input_frontend.sv
// ----------------------------------------------------------------------------
// tb_sw_input_frontend: directed vector bench for sw_input_frontend
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sw_input_frontend;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] raw_sw;
    logic [8:0] sw;
    logic       press;
    logic       rel;

    sw_input_frontend #(.DB_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_sw_i  (raw_sw),
        .sw_o      (sw),
        .press_o   (press),
        .release_o (rel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] raw;
        int         cycles;
        logic [8:0] pre_sw;
        logic [8:0] sw;
        int         npress;
        int         nrel;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int press_cnt, rel_cnt, both_cnt, sw8_seen, bad;
    vec_t tbl[7];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (press === 1'b1) press_cnt++;
        if (rel === 1'b1) rel_cnt++;
        if (press === 1'b1 && rel === 1'b1) both_cnt++;
        if (sw[8] === 1'b1) sw8_seen++;
    endtask

    // Drive raw, expect sw unchanged one clock before the 20-clock latency, new on it.
    task automatic apply_vec(input vec_t x, input string name);
        raw_sw    = x.raw;
        press_cnt = 0;
        rel_cnt   = 0;
        repeat (x.cycles - 1) tick();
        check({name, "_pre_sw"}, 32'(sw), 32'(x.pre_sw));
        tick();
        check({name, "_sw"}, 32'(sw), 32'(x.sw));
        check({name, "_press_last"}, 32'(press), 32'(x.npress));
        check({name, "_npress"}, 32'(press_cnt), 32'(x.npress));
        check({name, "_nrel"}, 32'(rel_cnt), 32'(x.nrel));
    endtask

    initial begin
        both_cnt = 0;
        press_cnt = 0;
        rel_cnt = 0;
        sw8_seen = 0;
        tbl[0] = '{9'h1FF, 20, 9'h000, 9'h1FF, 1, 0};  // out of reset, button already pressed
        tbl[1] = '{9'h05A, 20, 9'h1FF, 9'h05A, 0, 1};  // release with new data
        tbl[2] = '{9'h15A, 20, 9'h05A, 9'h15A, 1, 0};  // press, operand 5A
        tbl[3] = '{9'h1FF, 30, 9'h15A, 9'h15A, 0, 0};  // data change while held is hidden
        tbl[4] = '{9'h0FF, 20, 9'h15A, 9'h0FF, 0, 1};  // release exposes absorbed data
        tbl[5] = '{9'h0A5, 20, 9'h0FF, 9'h0A5, 0, 0};  // idle data tracking
        tbl[6] = '{9'h1A5, 20, 9'h0A5, 9'h1A5, 1, 0};  // press, operand A5

        reset  = 1'b1;
        raw_sw = 9'h1FF;
        tick();
        check("rst1_sw", 32'(sw), 32'h000);
        check("rst1_pulses", 32'({press, rel}), 32'h0);
        tick();
        check("rst2_sw", 32'(sw), 32'h000);
        check("rst2_pulses", 32'({press, rel}), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while held: straight to zero, no release pulse.
        reset = 1'b1;
        press_cnt = 0;
        rel_cnt = 0;
        tick();
        check("midrst_sw", 32'(sw), 32'h000);
        check("midrst_pulses", 32'(press_cnt + rel_cnt), 32'd0);
        reset = 1'b0;
        v = '{9'h1A5, 20, 9'h000, 9'h1A5, 1, 0};
        apply_vec(v, "after_rst");
        v = '{9'h0A5, 20, 9'h1A5, 9'h0A5, 0, 1};
        apply_vec(v, "rel_a5");

        // Button bouncing every 5 clocks must never be accepted.
        press_cnt = 0;
        sw8_seen = 0;
        for (int s = 0; s < 20; s++) begin
            raw_sw = (s % 2 == 0) ? 9'h1A5 : 9'h0A5;
            repeat (5) tick();
        end
        raw_sw = 9'h1A5;
        repeat (19) tick();
        check("bounce_no_press", 32'(press_cnt), 32'd0);
        check("bounce_sw8_quiet", 32'(sw8_seen), 32'd0);
        tick();
        check("bounce_press_edge", 32'(press), 32'd1);
        check("bounce_sw", 32'(sw), 32'h1A5);
        check("bounce_npress", 32'(press_cnt), 32'd1);
        v = '{9'h0A5, 20, 9'h1A5, 9'h0A5, 0, 1};
        apply_vec(v, "rel_bounce");

        // 15-sample glitch on bit 3 is rejected.
        bad = 0;
        press_cnt = 0;
        raw_sw = 9'h0AD;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (sw !== 9'h0A5) bad++;
        end
        raw_sw = 9'h0A5;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sw !== 9'h0A5) bad++;
        end
        check("glitch_reject", 32'(bad), 32'd0);
        check("glitch_no_press", 32'(press_cnt), 32'd0);

        // Minimum accepted width: stable through the final compare.
        raw_sw = 9'h0AD;
        repeat (17) tick();
        raw_sw = 9'h0A5;
        repeat (2) tick();
        check("pulse_pre", 32'(sw), 32'h0A5);
        tick();
        check("pulse_accept", 32'(sw), 32'h0AD);
        repeat (16) tick();
        check("pulse_hold", 32'(sw), 32'h0AD);
        tick();
        check("pulse_return", 32'(sw), 32'h0A5);

        check("press_release_exclusive", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
